// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction prefetch stage:
//   FETCH_XLEN      address / instruction width
//   FETCH_RESET_PC  default first fetch address after reset
//   ST_*            fetch FSM state encoding
//   fetch_entry_t   one buffered fetch: {pc, instr}
// ---------------------------------------------------------------------------
package fetch_pkg;

   localparam int                    FETCH_XLEN     = 32;
   localparam logic [FETCH_XLEN-1:0] FETCH_RESET_PC = 32'h0000_0000;

   localparam logic [1:0] ST_IDLE    = 2'd0;  // may issue a request
   localparam logic [1:0] ST_WAIT    = 2'd1;  // one request outstanding, keep its data
   localparam logic [1:0] ST_DISCARD = 2'd2;  // one request outstanding, drop its data

   typedef struct packed {
      logic [FETCH_XLEN-1:0] pc;
      logic [FETCH_XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO holding fetched {pc, instr} entries.
//   clk, rst_n   clock / async active-low reset
//   i_push       write i_wdata at tail (caller guarantees a free slot)
//   i_pop        drop head entry (ignored when empty)
//   i_flush      discard all entries; wins over push and pop
//   o_empty      no entries held
//   o_count      number of entries held (0..DEPTH)
//   o_head       head entry, read straight from registered storage
// ---------------------------------------------------------------------------
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = 2*FETCH_XLEN,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_push,
   input  logic [W-1:0]  i_wdata,
   input  logic          i_pop,
   input  logic          i_flush,
   output logic          o_empty,
   output logic [AW:0]   o_count,
   output logic [W-1:0]  o_head
);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_pop_ok;

   assign w_pop_ok = i_pop & (r_count != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({i_push, w_pop_ok})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// inst_fetch_unit
// Instruction prefetch stage: issues word fetches to a variable-latency
// memory (one outstanding), buffers returned words with their PC, and hands
// them to the core with valid/ready. A redirect flushes the buffer and
// restarts fetch at the new target.
//   clk, reset              clock / async active-low reset
//   redirect, redirect_pc   restart fetch at redirect_pc (low 2 bits ignored)
//   mem_req_*               fetch request handshake (valid/ready/addr)
//   mem_rsp_valid/_data     in-order response, one per accepted request
//   inst_valid/_ready       head-of-buffer handshake to the core
//   inst_pc, inst_data      head entry
// XLEN must match FETCH_XLEN since the buffered entry type comes from fetch_pkg.
// ---------------------------------------------------------------------------
module inst_fetch_unit
   import fetch_pkg::*;
#(
   parameter int              XLEN     = FETCH_XLEN,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = FETCH_RESET_PC
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            mem_req_valid,
   input  logic            mem_req_ready,
   output logic [XLEN-1:0] mem_req_addr,
   input  logic            mem_rsp_valid,
   input  logic [XLEN-1:0] mem_rsp_data,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] inst_pc,
   output logic [XLEN-1:0] inst_data
);

   localparam int              AW      = $clog2(DEPTH);
   localparam logic [AW:0]     LP_DEPTH = (AW+1)'(DEPTH);

   logic [1:0]      r_state, w_state_nxt;
   logic [XLEN-1:0] r_fetch_pc, w_fetch_pc_nxt;
   logic [XLEN-1:0] r_hold_addr, w_hold_nxt;   // address of a request held up across a redirect
   logic            r_pend, w_pend_nxt;        // held request belongs to a superseded stream
   logic [XLEN-1:0] r_req_pc;                  // PC of the outstanding request
   logic            r_run;                     // keeps requests off while reset is asserted
   logic            w_req_fire, w_push, w_pop, w_empty;
   logic [AW:0]     w_count;
   logic [XLEN-1:0] w_target;
   fetch_entry_t    w_wentry, w_head;
   logic            w_unused_bits;

   assign w_target      = {redirect_pc[XLEN-1:2], 2'b00};
   assign w_unused_bits = ^redirect_pc[1:0];

   // In IDLE nothing is outstanding, so the credit check is just count < DEPTH.
   // count can only fall while in IDLE, so valid stays up until accepted.
   assign mem_req_valid = r_run & (r_state == ST_IDLE) & (w_count < LP_DEPTH);
   assign mem_req_addr  = r_pend ? r_hold_addr : r_fetch_pc;
   assign w_req_fire    = mem_req_valid & mem_req_ready;

   assign w_push = (r_state == ST_WAIT) & mem_rsp_valid & ~redirect;
   assign w_pop  = inst_valid & inst_ready & ~redirect;

   always_comb begin
      w_state_nxt    = r_state;
      w_fetch_pc_nxt = r_fetch_pc;
      w_pend_nxt     = r_pend;
      w_hold_nxt     = r_hold_addr;
      case (r_state)
         ST_IDLE: if (w_req_fire) begin
            // A request accepted after (or on) a redirect is stale: drop its data
            // and leave fetch_pc pointing at the redirect target.
            w_state_nxt = (r_pend | redirect) ? ST_DISCARD : ST_WAIT;
            if (!r_pend) w_fetch_pc_nxt = r_fetch_pc + XLEN'(4);
            w_pend_nxt  = 1'b0;
         end
         ST_WAIT:    if (mem_rsp_valid) w_state_nxt = ST_IDLE;
         ST_DISCARD: if (mem_rsp_valid) w_state_nxt = ST_IDLE;
         default:    w_state_nxt = ST_IDLE;
      endcase
      if (redirect) begin
         w_fetch_pc_nxt = w_target;
         // Latch the visible request so its address holds while it waits.
         if (r_state == ST_IDLE && mem_req_valid && !mem_req_ready && !r_pend) begin
            w_pend_nxt = 1'b1;
            w_hold_nxt = r_fetch_pc;
         end
         // If the response lands on the redirect edge it is simply dropped and
         // nothing is left outstanding.
         if (r_state == ST_WAIT && !mem_rsp_valid) w_state_nxt = ST_DISCARD;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_fetch_pc  <= RESET_PC;
         r_hold_addr <= RESET_PC;
         r_pend      <= 1'b0;
         r_req_pc    <= '0;
         r_run       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_fetch_pc  <= w_fetch_pc_nxt;
         r_hold_addr <= w_hold_nxt;
         r_pend      <= w_pend_nxt;
         r_run       <= 1'b1;
         if (w_req_fire) r_req_pc <= mem_req_addr;
      end
   end

   assign w_wentry = '{pc: r_req_pc, instr: mem_rsp_data};

   fetch_fifo #(
      .DEPTH (DEPTH),
      .W     ($bits(fetch_entry_t))
   ) u_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .i_push  (w_push),
      .i_wdata (w_wentry),
      .i_pop   (w_pop),
      .i_flush (redirect),
      .o_empty (w_empty),
      .o_count (w_count),
      .o_head  (w_head)
   );

   assign inst_valid = ~w_empty;
   assign inst_pc    = w_head.pc;
   assign inst_data  = w_head.instr;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_unit
// Directed bench: a behavioural memory answers each accepted request after
// 'lat' cycles with data = addr ^ 32'hDEAD_0000; accepted request addresses
// and consumed instructions are logged and compared with hand-computed values.
// ---------------------------------------------------------------------------
module tb_inst_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_pc;
   logic [31:0] inst_data;

   int checks = 0;
   int errors = 0;
   int lat    = 1;
   int rsp_cnt = 0;
   logic [31:0] rsp_addr;

   logic [31:0] req_log [$];
   logic [31:0] pop_pc  [$];
   logic [31:0] pop_dat [$];

   inst_fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .clk           (clk),
      .reset         (reset),
      .redirect      (redirect),
      .redirect_pc   (redirect_pc),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_req_addr  (mem_req_addr),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_data  (mem_rsp_data),
      .inst_valid    (inst_valid),
      .inst_ready    (inst_ready),
      .inst_pc       (inst_pc),
      .inst_data     (inst_data)
   );

   always #5 clk = ~clk;

   // Memory model and monitor, evaluated mid-cycle when everything is stable.
   initial begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      rsp_addr      = '0;
      forever begin
         @(negedge clk);
         mem_rsp_valid = 1'b0;
         if (!reset) begin
            rsp_cnt = 0;
         end else begin
            if (rsp_cnt > 0) begin
               rsp_cnt--;
               if (rsp_cnt == 0) begin
                  mem_rsp_valid = 1'b1;
                  mem_rsp_data  = rsp_addr ^ 32'hDEAD_0000;
               end
            end
            if (mem_req_valid && mem_req_ready) begin
               req_log.push_back(mem_req_addr);
               rsp_addr = mem_req_addr;
               rsp_cnt  = lat;
            end
            if (inst_valid && inst_ready && !redirect) begin
               pop_pc.push_back(inst_pc);
               pop_dat.push_back(inst_data);
            end
         end
      end
   end

   function automatic logic [31:0] req_at(input int i);
      return (i < req_log.size()) ? req_log[i] : 32'hxxxx_xxxx;
   endfunction
   function automatic logic [31:0] pc_at(input int i);
      return (i < pop_pc.size()) ? pop_pc[i] : 32'hxxxx_xxxx;
   endfunction
   function automatic logic [31:0] dat_at(input int i);
      return (i < pop_dat.size()) ? pop_dat[i] : 32'hxxxx_xxxx;
   endfunction

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int l, input logic rdy, input logic ird);
      @(posedge clk); #1;
      reset = 1'b0; redirect = 1'b0; redirect_pc = '0;
      mem_req_ready = rdy; inst_ready = ird; lat = l;
      req_log.delete(); pop_pc.delete(); pop_dat.delete();
      cycles(2);
      reset = 1'b1;
   endtask

   task automatic wait_req(input int n, input string tag);
      int k = 0;
      while (req_log.size() < n && k < 200) begin
         cycles(1);
         k++;
      end
      if (req_log.size() < n) begin
         checks++; errors++;
         $display("FAIL %s timeout: requests seen %0d, wanted %0d", tag, req_log.size(), n);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; redirect = 1'b0; redirect_pc = '0;
      mem_req_ready = 1'b0; inst_ready = 1'b0;
      #2;
      checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got %b exp 0", mem_req_valid); end
      checks++; if (mem_req_addr !== 32'h0) begin errors++; $display("FAIL rst_req_addr got %h exp 00000000", mem_req_addr); end
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_inst_valid got %b exp 0", inst_valid); end
      checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL rst_inst_pc got %h exp 00000000", inst_pc); end
      checks++; if (inst_data !== 32'h0) begin errors++; $display("FAIL rst_inst_data got %h exp 00000000", inst_data); end
   endtask

   task automatic test_stream();
      do_reset(1, 1'b1, 1'b1);
      cycles(14);
      checks++; if (req_at(0) !== 32'h0) begin errors++; $display("FAIL stream_req0 got %h exp 00000000", req_at(0)); end
      checks++; if (req_at(1) !== 32'h4) begin errors++; $display("FAIL stream_req1 got %h exp 00000004", req_at(1)); end
      checks++; if (req_at(2) !== 32'h8) begin errors++; $display("FAIL stream_req2 got %h exp 00000008", req_at(2)); end
      checks++; if (pc_at(0) !== 32'h0) begin errors++; $display("FAIL stream_pc0 got %h exp 00000000", pc_at(0)); end
      checks++; if (pc_at(1) !== 32'h4) begin errors++; $display("FAIL stream_pc1 got %h exp 00000004", pc_at(1)); end
      checks++; if (pc_at(2) !== 32'h8) begin errors++; $display("FAIL stream_pc2 got %h exp 00000008", pc_at(2)); end
      checks++; if (dat_at(0) !== 32'hDEAD_0000) begin errors++; $display("FAIL stream_dat0 got %h exp dead0000", dat_at(0)); end
      checks++; if (dat_at(2) !== 32'hDEAD_0008) begin errors++; $display("FAIL stream_dat2 got %h exp dead0008", dat_at(2)); end
   endtask

   task automatic test_full();
      do_reset(1, 1'b1, 1'b0);
      cycles(20);
      checks++; if (req_log.size() != 4) begin errors++; $display("FAIL full_reqs got %0d exp 4", req_log.size()); end
      checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL full_req_valid got %b exp 0", mem_req_valid); end
      checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL full_head_pc got %h exp 00000000", inst_pc); end
      inst_ready = 1'b1;
      cycles(1);
      inst_ready = 1'b0;
      checks++; if (inst_pc !== 32'h4) begin errors++; $display("FAIL full_head_after_pop got %h exp 00000004", inst_pc); end
      cycles(10);
      checks++; if (req_log.size() != 5) begin errors++; $display("FAIL full_one_more got %0d exp 5", req_log.size()); end
      checks++; if (req_at(4) !== 32'h10) begin errors++; $display("FAIL full_req4 got %h exp 00000010", req_at(4)); end
      checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL full_refilled_valid got %b exp 0", mem_req_valid); end
   endtask

   task automatic test_redirect_wait();
      do_reset(3, 1'b1, 1'b0);
      wait_req(3, "rdw_wait");
      checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL rdw_pre_valid got %b exp 1", inst_valid); end
      redirect = 1'b1; redirect_pc = 32'h100;
      cycles(1);
      redirect = 1'b0;
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rdw_flushed got %b exp 0", inst_valid); end
      inst_ready = 1'b1;
      cycles(20);
      checks++; if (req_at(3) !== 32'h100) begin errors++; $display("FAIL rdw_req3 got %h exp 00000100", req_at(3)); end
      checks++; if (pc_at(0) !== 32'h100) begin errors++; $display("FAIL rdw_first_pc got %h exp 00000100", pc_at(0)); end
      checks++; if (dat_at(0) !== 32'hDEAD_0100) begin errors++; $display("FAIL rdw_first_dat got %h exp dead0100", dat_at(0)); end
   endtask

   task automatic test_redirect_pending();
      int n0;
      do_reset(1, 1'b1, 1'b1);
      wait_req(4, "rdp_wait");
      mem_req_ready = 1'b0;
      cycles(3);
      checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL rdp_held_valid got %b exp 1", mem_req_valid); end
      checks++; if (mem_req_addr !== 32'h10) begin errors++; $display("FAIL rdp_held_addr got %h exp 00000010", mem_req_addr); end
      n0 = pop_pc.size();
      redirect = 1'b1; redirect_pc = 32'h203;
      cycles(1);
      redirect = 1'b0;
      checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL rdp_valid_after got %b exp 1", mem_req_valid); end
      checks++; if (mem_req_addr !== 32'h10) begin errors++; $display("FAIL rdp_addr_after got %h exp 00000010", mem_req_addr); end
      cycles(2);
      checks++; if (mem_req_addr !== 32'h10) begin errors++; $display("FAIL rdp_addr_later got %h exp 00000010", mem_req_addr); end
      mem_req_ready = 1'b1;
      cycles(12);
      checks++; if (req_at(4) !== 32'h10) begin errors++; $display("FAIL rdp_req4 got %h exp 00000010", req_at(4)); end
      checks++; if (req_at(5) !== 32'h200) begin errors++; $display("FAIL rdp_req5 got %h exp 00000200", req_at(5)); end
      checks++; if (pc_at(n0) !== 32'h200) begin errors++; $display("FAIL rdp_first_pc got %h exp 00000200", pc_at(n0)); end
   endtask

   task automatic test_back_to_back();
      do_reset(1, 1'b1, 1'b0);
      wait_req(3, "b2b_wait");
      // FIFO holds 0x0,0x4; response for 0x8 lands on the next edge with the pop.
      inst_ready = 1'b1; mem_req_ready = 1'b0;
      cycles(1);
      inst_ready = 1'b0;
      checks++; if (inst_pc !== 32'h4) begin errors++; $display("FAIL b2b_head_pc got %h exp 00000004", inst_pc); end
      checks++; if (inst_data !== 32'hDEAD_0004) begin errors++; $display("FAIL b2b_head_dat got %h exp dead0004", inst_data); end
      checks++; if (pc_at(0) !== 32'h0) begin errors++; $display("FAIL b2b_pop0 got %h exp 00000000", pc_at(0)); end
      inst_ready = 1'b1;
      cycles(2);
      inst_ready = 1'b0;
      checks++; if (pc_at(1) !== 32'h4) begin errors++; $display("FAIL b2b_pop1 got %h exp 00000004", pc_at(1)); end
      checks++; if (pc_at(2) !== 32'h8) begin errors++; $display("FAIL b2b_pop2 got %h exp 00000008", pc_at(2)); end
      checks++; if (dat_at(2) !== 32'hDEAD_0008) begin errors++; $display("FAIL b2b_dat2 got %h exp dead0008", dat_at(2)); end
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained got %b exp 0", inst_valid); end
   endtask

   task automatic test_wrap();
      do_reset(1, 1'b1, 1'b1);
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
      cycles(1);
      redirect = 1'b0;
      cycles(10);
      checks++; if (req_at(0) !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req0 got %h exp fffffffc", req_at(0)); end
      checks++; if (req_at(1) !== 32'h0) begin errors++; $display("FAIL wrap_req1 got %h exp 00000000", req_at(1)); end
      checks++; if (pc_at(0) !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc0 got %h exp fffffffc", pc_at(0)); end
      checks++; if (dat_at(0) !== 32'h2152_FFFC) begin errors++; $display("FAIL wrap_dat0 got %h exp 2152fffc", dat_at(0)); end
      checks++; if (pc_at(1) !== 32'h0) begin errors++; $display("FAIL wrap_pc1 got %h exp 00000000", pc_at(1)); end
   endtask

   task automatic test_reset_mid();
      do_reset(4, 1'b1, 1'b0);
      wait_req(2, "rmid_wait");
      checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid got %b exp 1", inst_valid); end
      #2;
      reset = 1'b0;
      #1;
      checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rmid_req_valid got %b exp 0", mem_req_valid); end
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rmid_inst_valid got %b exp 0", inst_valid); end
      checks++; if (mem_req_addr !== 32'h0) begin errors++; $display("FAIL rmid_req_addr got %h exp 00000000", mem_req_addr); end
      cycles(2);
      req_log.delete(); pop_pc.delete(); pop_dat.delete();
      lat = 1; inst_ready = 1'b1;
      reset = 1'b1;
      cycles(8);
      checks++; if (req_at(0) !== 32'h0) begin errors++; $display("FAIL rmid_first_req got %h exp 00000000", req_at(0)); end
      checks++; if (dat_at(0) !== 32'hDEAD_0000) begin errors++; $display("FAIL rmid_first_dat got %h exp dead0000", dat_at(0)); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_full();
      test_redirect_wait();
      test_redirect_pending();
      test_back_to_back();
      test_wrap();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
Instruction prefetch stage that sits directly upstream of the single-cycle core's instruction decode/register-file path. It replaces the combinational instruction-memory read with a handshaked fetch port to a variable-latency instruction memory. Fetched words are buffered in a small FIFO and presented to the core as {pc, instruction} with valid/ready. A redirect input (taken branch/jump from the core's next-PC mux) flushes the buffer and restarts fetch at the target.

Parameters:
DEPTH, 4, FIFO entries (power of 2, >=2)
RESET_PC, 32'h0000_0000, first fetch address after reset
XLEN, 32, address/instruction width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
redirect  in  1  core requests fetch restart at redirect_pc
redirect_pc  in  XLEN  restart address; bits [1:0] ignored (treated as 0)
mem_req_valid  out  1  fetch request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  XLEN  word-aligned fetch address
mem_rsp_valid  in  1  response data valid (one per accepted request, in order)
mem_rsp_data  in  XLEN  fetched instruction word
inst_valid  out  1  head FIFO entry valid
inst_ready  in  1  core consumes head entry
inst_pc  out  XLEN  PC of head entry
inst_data  out  XLEN  instruction of head entry

Behaviour:
- Reset (reset=0, async): fetch_pc=RESET_PC, FIFO empty, state=IDLE, mem_req_valid=0, mem_req_addr=RESET_PC, inst_valid=0, inst_pc=0, inst_data=0.
- At most one outstanding memory request. Request handshake is complete when mem_req_valid & mem_req_ready are both high on a rising edge.
- Credit rule: a request is issued only when count + outstanding < DEPTH, so a response always has a free slot. Responses never back-pressure.
- FSM states:
  - IDLE: mem_req_valid = (credit available); mem_req_addr = fetch_pc. On accept: fetch_pc += 4 (wraps modulo 2^XLEN), go to WAIT.
  - WAIT: mem_req_valid=0. On mem_rsp_valid, push {req_pc, mem_rsp_data} and go to IDLE.
  - DISCARD: mem_req_valid=0. On mem_rsp_valid, drop the data and go to IDLE.
- Once asserted, mem_req_valid and mem_req_addr stay stable until accepted, including across a redirect.
- Redirect (highest priority, same edge):
  - FIFO is flushed and fetch_pc = {redirect_pc[XLEN-1:2], 2'b00}.
  - In WAIT: go to DISCARD.
  - In DISCARD: stay in DISCARD.
  - In IDLE with a pending unaccepted request: the request stays up; when it is accepted, fetch_pc is not incremented and the state goes to DISCARD. The redirect target is issued afterwards.
  - A response arriving on the redirect edge is dropped.
  - A pop on the redirect edge is ignored (FIFO empty next cycle).
  - Multiple consecutive redirects: the last one wins.
- Output side: inst_valid = FIFO non-empty; inst_pc/inst_data reflect the head entry (registered storage, no bypass).
  - Latency: a response on edge N gives inst_valid=1 after edge N; minimum request-to-inst_valid latency is memory latency + 1 cycle.
  - Pop when inst_valid & inst_ready.
  - Simultaneous push and pop: count unchanged, both take effect.
- Full: no new request is issued while count + outstanding == DEPTH. Empty: inst_valid=0; inst_ready is ignored.
- Reset asserted mid-transaction: all state clears immediately. The memory side is required to be reset by the same signal, so no stale response arrives afterwards.

Decomposition:
- Shared package fetch_pkg: XLEN, RESET_PC default, FSM state encoding (IDLE/WAIT/DISCARD), fetch-entry struct {pc, instr}.
- One sub-module fetch_fifo: synchronous FIFO, DEPTH x 2*XLEN, with push/pop/flush/count, async active-low reset, registered head output.

Test Plan:
- Reset release, zero-wait memory (ready=1, rsp 1 cycle later), inst_ready=1 -> requests at 0x0, 0x4, 0x8…; inst_pc 0x0, 0x4, 0x8 in order with the matching data.
- inst_ready=0, DEPTH=4 -> exactly 4 requests issued, then mem_req_valid=0. Raise inst_ready for one cycle -> exactly one new request.
- Redirect to 0x100 while in WAIT for 0x8 -> 0x8 response dropped; next request addr 0x100; first inst_pc out is 0x100; FIFO flushed.
- Hold mem_req_ready=0 with a request at 0x10 pending, pulse redirect to 0x203 -> addr stays 0x10 until accepted, its response is discarded, next request addr 0x200.
- Push and pop on the same edge with the FIFO at 2 entries -> count stays 2, order preserved; fetch_pc=0xFFFF_FFFC accept -> next addr 0x0.
- Assert reset mid-WAIT -> mem_req_valid=0 and inst_valid=0 immediately (async); after release, the first request addr equals RESET_PC.
